// File: rtl/writeback_unit.sv
// Writeback unit: LSU-priority arbiter into a result FIFO that drains to the register file write port.
// Optional register scoreboard enabled by defining WRITEBACK_SCOREBOARD_EN.
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        stall,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  addr_rs0,
    input  logic [4:0]  addr_rs1,
    output logic        busy_rs0,
    output logic        busy_rs1,
    output logic        we,
    output logic [4:0]  addr_write2,
    output logic [31:0] data_write2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic          not_full, empty, push, pop;
    logic [4:0]    push_rd;
    logic [31:0]   push_data;

    assign not_full  = (count_q < FULL);
    assign empty     = (count_q == '0);
    assign lsu_ready = not_full;
    assign alu_ready = not_full && !lsu_valid;

    // rd==0 results still handshake but never occupy a FIFO slot
    always_comb begin
        push      = 1'b0;
        push_rd   = alu_rd;
        push_data = alu_data;
        if (lsu_valid && not_full) begin
            push_rd   = lsu_rd;
            push_data = lsu_data;
            push      = (lsu_rd != 5'd0);
        end else if (alu_valid && not_full) begin
            push      = (alu_rd != 5'd0);
        end
    end

    assign we          = !empty && !stall;
    assign pop         = we;
    assign addr_write2 = empty ? 5'd0  : rd_mem[rd_ptr_q];
    assign data_write2 = empty ? 32'd0 : data_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= push_rd;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

`ifdef WRITEBACK_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Clear before set so a same-edge issue of the popped register stays busy
    always_comb begin
        busy_d = busy_q;
        if (pop)
            busy_d[addr_write2] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign busy_rs0 = busy_q[addr_rs0];
    assign busy_rs1 = busy_q[addr_rs1];
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid, issue_rd, addr_rs0, addr_rs1};
    assign busy_rs0  = 1'b0;
    assign busy_rs1  = 1'b0;
`endif

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid  input  1  ALU result offered.
REQ-005 alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 lsu_valid  input  1  load result offered.
REQ-009 lsu_ready  output  1  load result accepted this cycle when lsu_valid is also high.
REQ-010 lsu_rd  input  5  load destination register.
REQ-011 lsu_data  input  32  load result.
REQ-012 stall  input  1  register file write port unavailable.
REQ-013 issue_valid  input  1  instruction issued with a destination.
REQ-014 issue_rd  input  5  issued destination register.
REQ-015 addr_rs0, addr_rs1  input  5 each  scoreboard query addresses.
REQ-016 busy_rs0, busy_rs1  output  1 each  queried register has a pending write.
REQ-017 we  output  1  register file write enable.
REQ-018 addr_write2  output  5  register file write address.
REQ-019 data_write2  output  32  register file write data.

Function
REQ-020 Arbitration: LSU priority; lsu_ready = (count<DEPTH); alu_ready = (count<DEPTH) && !lsu_valid; at most one push per cycle.
REQ-021 Accepted result with rd==0 completes its handshake but is not pushed (no we, count unchanged).
REQ-022 FIFO head drives write port combinationally: we = (count!=0) && !stall; addr_write2/data_write2 = head rd/data; when count==0, addr_write2=0 and data_write2=0.
REQ-023 Pop occurs on every edge where we==1; latency from acceptance edge to we high is one cycle if FIFO empty and stall low.
REQ-024 Full boundary: count==DEPTH deasserts both readies even if a pop occurs that cycle (no pass-through).
REQ-025 Simultaneous push and pop: count unchanged, order preserved; pointers wrap modulo DEPTH.
REQ-026 Writes leave the unit in acceptance order.
REQ-027 Scoreboard: 32 busy bits, bit 0 hard-wired 0; issue_valid with issue_rd!=0 sets bit; pop clears bit of popped rd.
REQ-028 Same-edge set and clear of one register: set wins.
REQ-029 busy_rs0/busy_rs1 are combinational reads of busy bits (reflect state before the current edge).

Reset
REQ-030 rst low immediately clears FIFO pointers, count and all busy bits: we=0, addr_write2=0, data_write2=0, alu_ready=lsu_ready=1, busy_rs*=0.
REQ-031 Reset mid-operation discards all queued results; no write issues while rst low or on the first edge after release unless pushed.

Configuration
REQ-032 Macro WRITEBACK_SCOREBOARD_EN defined: REQ-027..029 implemented.
REQ-033 Macro absent: no busy storage, issue_* ignored, busy_rs0=busy_rs1=0 constantly; FIFO behaviour identical.

Verification
REQ-034 alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF, FIFO empty -> next cycle we=1, addr_write2=5, data_write2=0xDEADBEEF, one cycle only.
REQ-035 lsu_valid and alu_valid same cycle (rd 3 / rd 4) -> lsu_ready=1, alu_ready=0; rd 3 written first, ALU accepted next cycle, rd 4 written after.
REQ-036 stall=1, push 5 results, DEPTH=4 -> readies drop after 4th; release stall -> 4 writes in order on consecutive cycles, then 5th.
REQ-037 alu_rd=0, data 0x12345678 -> alu_ready=1, we stays 0, count stays 0.
REQ-038 issue rd 7 -> busy_rs0 (addr_rs0=7) =1; write rd 7 while issue rd 7 same edge -> busy stays 1; later write rd 7 -> busy 0.
REQ-039 3 entries queued, rst pulsed low mid-cycle -> we=0 immediately, no writes after release, busy_rs*=0.
